// File: rtl/cache_refill_engine.sv
// cache_refill_engine
//
// Handles cache misses one at a time. For each accepted miss it reads the
// new line from external memory and writes it into the cache data RAM. It
// then captures the line that was evicted, and writes that line back to
// memory if it was dirty.
//
// Handshake rule (applies to miss_*, mem_rd_req_*, mem_wr_req_*): a transfer
// happens on a rising clk edge where valid and ready are both 1. Once valid
// is raised, it stays high with its payload unchanged until that transfer.
// mem_rd_resp_valid has no ready. It is a one-cycle strobe and is only
// consumed in RD_WAIT.
//
// Data RAM contract: the RAM is read-first. In the cycle after memEN_2 = 1,
// Data_repl holds the old contents of Set_Index_repl, which is the victim
// line.
//
// Optional build macro: REFILL_STATS_EN. When defined, refill_cnt and wb_cnt
// are saturating 32-bit event counters. When not defined, both are tied to 0.
//
// Ports:
//   clk, RST           clock; asynchronous active-high reset
//   miss_*             miss request from the cache controller
//   memEN_2            one-cycle fill strobe to the data RAM
//   Set_Index_repl     {set, index} fill location (holds its last value)
//   Data_mem_in        fill data (holds its last value)
//   Data_repl          victim data read back from the data RAM
//   mem_rd_*           external read request / response
//   mem_wr_*           external writeback request
//   fill_done          one-cycle pulse when a line has been installed
//   fill_set_index     location of the installed line, valid with fill_done
//   refill_cnt, wb_cnt statistics counters
//   state_dbg          current FSM state encoding, for observation

module cache_refill_engine #(
  parameter int DATA_WIDTH = 512,
  parameter int SET_CNT    = 2,
  parameter int BLOCK_CNT  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          RST,

  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [SET_CNT+BLOCK_CNT-1:0]  miss_set_index,
  input  logic [ADDR_WIDTH-1:0]         miss_addr,
  input  logic                          miss_dirty,
  input  logic [ADDR_WIDTH-1:0]         miss_victim_addr,

  output logic                          memEN_2,
  output logic [SET_CNT+BLOCK_CNT-1:0]  Set_Index_repl,
  output logic [DATA_WIDTH-1:0]         Data_mem_in,
  input  logic [DATA_WIDTH-1:0]         Data_repl,

  output logic                          mem_rd_req_valid,
  input  logic                          mem_rd_req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic                          mem_rd_resp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rd_resp_data,

  output logic                          mem_wr_req_valid,
  input  logic                          mem_wr_req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,

  output logic                          fill_done,
  output logic [SET_CNT+BLOCK_CNT-1:0]  fill_set_index,

  output logic [31:0]                   refill_cnt,
  output logic [31:0]                   wb_cnt,

  output logic [2:0]                    state_dbg
);

  localparam int SI_W = SET_CNT + BLOCK_CNT;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    SWAP    = 3'd3,
    CAPTURE = 3'd4,
    WB_REQ  = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [SI_W-1:0]         set_index_q;
  logic                    dirty_q;
  logic [ADDR_WIDTH-1:0]   victim_addr_q;

  assign state_dbg      = state;
  assign fill_set_index = set_index_q;

  // State register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobes. All outputs are decoded from the state only, so
  // there is no combinational path from any input to any output.
  always_comb begin
    state_nxt        = state;
    miss_ready       = 1'b0;
    mem_rd_req_valid = 1'b0;
    mem_wr_req_valid = 1'b0;
    memEN_2          = 1'b0;
    fill_done        = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        mem_rd_req_valid = 1'b1;
        if (mem_rd_req_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rd_resp_valid) state_nxt = SWAP;
      end
      SWAP: begin
        memEN_2   = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // The read-first RAM presents the victim on Data_repl in this cycle.
        fill_done = 1'b1;
        state_nxt = dirty_q ? WB_REQ : IDLE;
      end
      WB_REQ: begin
        mem_wr_req_valid = 1'b1;
        if (mem_wr_req_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Miss descriptor. It is latched at acceptance, so the controller is free
  // to change the miss_* inputs afterwards. mem_rd_addr is loaded here and
  // does not change until the next miss is accepted.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      set_index_q   <= '0;
      dirty_q       <= 1'b0;
      victim_addr_q <= '0;
      mem_rd_addr   <= '0;
    end else if (state == IDLE && miss_valid) begin
      set_index_q   <= miss_set_index;
      dirty_q       <= miss_dirty;
      victim_addr_q <= miss_victim_addr;
      mem_rd_addr   <= miss_addr;
    end
  end

  // Fill buffer. Data_mem_in and Set_Index_repl are themselves the buffer.
  // They are loaded as the response arrives and keep their values after
  // SWAP.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      Set_Index_repl <= '0;
      Data_mem_in    <= '0;
    end else if (state == RD_WAIT && mem_rd_resp_valid) begin
      Set_Index_repl <= set_index_q;
      Data_mem_in    <= mem_rd_resp_data;
    end
  end

  // Writeback buffer. It is loaded only for dirty victims, in CAPTURE.
  // Because of that it stays stable for the whole of WB_REQ.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (state == CAPTURE && dirty_q) begin
      mem_wr_addr <= victim_addr_q;
      mem_wr_data <= Data_repl;
    end
  end

`ifdef REFILL_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      refill_cnt <= '0;
      wb_cnt     <= '0;
    end else begin
      if (fill_done && refill_cnt != 32'hFFFF_FFFF)
        refill_cnt <= refill_cnt + 32'd1;
      if (mem_wr_req_valid && mem_wr_req_ready && wb_cnt != 32'hFFFF_FFFF)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`else
  assign refill_cnt = '0;
  assign wb_cnt     = '0;
`endif

endmodule

// File: tb/tb_cache_refill_engine.sv
// Testbench for cache_refill_engine.
// It contains a read-first data RAM model and drives memory handshakes from
// directed steps with random data and stalls. A reference model tracks the
// expected cache line contents and the expected writebacks.

module tb_cache_refill_engine;

  localparam int DW   = 512;
  localparam int SI_W = 10;
  localparam int AW   = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic RST;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            miss_valid, miss_ready, miss_dirty;
  logic [SI_W-1:0] miss_set_index;
  logic [AW-1:0]   miss_addr, miss_victim_addr;
  logic            memEN_2;
  logic [SI_W-1:0] Set_Index_repl;
  logic [DW-1:0]   Data_mem_in, Data_repl;
  logic            mem_rd_req_valid, mem_rd_req_ready, mem_rd_resp_valid;
  logic [AW-1:0]   mem_rd_addr;
  logic [DW-1:0]   mem_rd_resp_data;
  logic            mem_wr_req_valid, mem_wr_req_ready;
  logic [AW-1:0]   mem_wr_addr;
  logic [DW-1:0]   mem_wr_data;
  logic            fill_done;
  logic [SI_W-1:0] fill_set_index;
  logic [31:0]     refill_cnt, wb_cnt;
  logic [2:0]      state_dbg;

  cache_refill_engine #(
    .DATA_WIDTH(DW), .SET_CNT(2), .BLOCK_CNT(8), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .RST(RST),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_set_index(miss_set_index), .miss_addr(miss_addr),
    .miss_dirty(miss_dirty), .miss_victim_addr(miss_victim_addr),
    .memEN_2(memEN_2), .Set_Index_repl(Set_Index_repl),
    .Data_mem_in(Data_mem_in), .Data_repl(Data_repl),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_resp_valid(mem_rd_resp_valid),
    .mem_rd_resp_data(mem_rd_resp_data),
    .mem_wr_req_valid(mem_wr_req_valid), .mem_wr_req_ready(mem_wr_req_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .fill_done(fill_done), .fill_set_index(fill_set_index),
    .refill_cnt(refill_cnt), .wb_cnt(wb_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- environment: read-first data RAM ----------------
  logic [DW-1:0]   env_ram [int];
  logic            preload_en;
  logic [SI_W-1:0] preload_idx;
  logic [DW-1:0]   preload_data;

  initial Data_repl = '0;
  always @(posedge clk) begin
    if (preload_en) begin
      env_ram[int'(preload_idx)] = preload_data;
    end else if (memEN_2) begin
      Data_repl <= env_ram.exists(int'(Set_Index_repl)) ? env_ram[int'(Set_Index_repl)] : '0;
      env_ram[int'(Set_Index_repl)] = Data_mem_in;
    end
  end

  // Handshake / strobe monitors
  int rd_hs = 0, wr_hs = 0, en_cnt = 0;
  always @(posedge clk) begin
    if (mem_rd_req_valid && mem_rd_req_ready) rd_hs++;
    if (mem_wr_req_valid && mem_wr_req_ready) wr_hs++;
    if (memEN_2) en_cnt++;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_ram [int];
  logic [DW-1:0] exp_q [$];       // expected writeback data
  logic [AW-1:0] exp_addr_q [$];  // expected writeback address
  int exp_refills = 0;
  int exp_wbs     = 0;
  int pass_cnt    = 0;
  int total_cnt   = 0;
  int fail_cnt    = 0;

  function automatic logic [DW-1:0] ref_read(input int idx);
    if (ref_ram.exists(idx)) return ref_ram[idx];
    return '0;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    check(tag, DW'(obs), DW'(exp));
  endtask

  task automatic check_stats(input string tag);
`ifdef REFILL_STATS_EN
    check({tag, "_refill_cnt"}, DW'(refill_cnt), DW'(exp_refills));
    check({tag, "_wb_cnt"}, DW'(wb_cnt), DW'(exp_wbs));
`else
    check({tag, "_refill_cnt"}, DW'(refill_cnt), DW'(0));
    check({tag, "_wb_cnt"}, DW'(wb_cnt), DW'(0));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete miss. The task is entered just after a rising edge with the
  // engine idle, and it returns the same way.
  task automatic do_miss(input logic [SI_W-1:0] si, input logic [AW-1:0] addr,
                         input logic dirty, input logic [AW-1:0] vaddr,
                         input int rd_stall, input int resp_wait, input int wr_stall,
                         input logic stray, input logic [DW-1:0] rdata);
    int rd0, wr0, en0;
    logic [DW-1:0] victim;
    rd0 = rd_hs; wr0 = wr_hs; en0 = en_cnt;
    miss_valid = 1'b1; miss_set_index = si; miss_addr = addr;
    miss_dirty = dirty; miss_victim_addr = vaddr;
    @(negedge clk);
    check_b("miss_ready_idle", miss_ready, 1'b1);
    tick();
    // Scramble the request fields so that latching is exercised.
    miss_valid = 1'b0; miss_set_index = SI_W'($urandom); miss_addr = $urandom;
    miss_dirty = ~dirty; miss_victim_addr = $urandom;
    for (int i = 0; i < rd_stall; i++) begin
      mem_rd_req_ready = 1'b0;
      if (stray && i == 0) begin
        mem_rd_resp_valid = 1'b1; mem_rd_resp_data = rand_line();
      end
      @(negedge clk);
      check_b("rd_valid_stall", mem_rd_req_valid, 1'b1);
      check("rd_addr_stall", DW'(mem_rd_addr), DW'(addr));
      check_b("miss_ready_busy", miss_ready, 1'b0);
      check_b("no_en_rdreq", memEN_2, 1'b0);
      tick();
      mem_rd_resp_valid = 1'b0;
    end
    mem_rd_req_ready = 1'b1;
    @(negedge clk);
    check_b("rd_valid", mem_rd_req_valid, 1'b1);
    check("rd_addr", DW'(mem_rd_addr), DW'(addr));
    tick();
    mem_rd_req_ready = 1'b0;
    for (int i = 0; i < resp_wait; i++) begin
      @(negedge clk);
      check_b("rd_valid_wait", mem_rd_req_valid, 1'b0);
      tick();
    end
    mem_rd_resp_valid = 1'b1; mem_rd_resp_data = rdata;
    @(negedge clk);
    check_b("no_en_wait", memEN_2, 1'b0);
    tick();
    mem_rd_resp_valid = 1'b0; mem_rd_resp_data = rand_line();
    // Fill strobe cycle. The reference model installs the line here.
    @(negedge clk);
    check_b("swap_en", memEN_2, 1'b1);
    check("swap_idx", DW'(Set_Index_repl), DW'(si));
    check("swap_data", Data_mem_in, rdata);
    check_b("swap_no_done", fill_done, 1'b0);
    victim = ref_read(int'(si));
    ref_ram[int'(si)] = rdata;
    exp_refills++;
    if (dirty) begin
      exp_q.push_back(victim);
      exp_addr_q.push_back(vaddr);
    end
    tick();
    @(negedge clk);
    check_b("fill_done", fill_done, 1'b1);
    check("fill_set_index", DW'(fill_set_index), DW'(si));
    check_b("en_one_cycle", memEN_2, 1'b0);
    check_b("wr_after_done", mem_wr_req_valid, 1'b0);
    tick();
    if (dirty) begin
      for (int i = 0; i < wr_stall; i++) begin
        mem_wr_req_ready = 1'b0;
        @(negedge clk);
        check_b("wr_valid_stall", mem_wr_req_valid, 1'b1);
        check("wr_addr_stall", DW'(mem_wr_addr), DW'(exp_addr_q[0]));
        check("wr_data_stall", mem_wr_data, exp_q[0]);
        check_b("miss_ready_wb", miss_ready, 1'b0);
        tick();
      end
      mem_wr_req_ready = 1'b1;
      @(negedge clk);
      check_b("wr_valid", mem_wr_req_valid, 1'b1);
      check("wr_addr", DW'(mem_wr_addr), DW'(exp_addr_q[0]));
      check("wr_data", mem_wr_data, exp_q[0]);
      tick();
      mem_wr_req_ready = 1'b0;
      void'(exp_q.pop_front());
      void'(exp_addr_q.pop_front());
      exp_wbs++;
    end
    @(negedge clk);
    check_b("miss_ready_back", miss_ready, 1'b1);
    check_b("wr_idle", mem_wr_req_valid, 1'b0);
    check("hold_idx", DW'(Set_Index_repl), DW'(si));
    check("hold_data", Data_mem_in, rdata);
    check("rd_hs_count", DW'(rd_hs - rd0), DW'(1));
    check("wr_hs_count", DW'(wr_hs - wr0), DW'(dirty ? 1 : 0));
    check("en_count", DW'(en_cnt - en0), DW'(1));
    check_stats("miss");
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int en0, rd0;
    logic [DW-1:0] line_a5, line_5a;
    line_a5 = {64{8'hA5}};
    line_5a = {64{8'h5A}};
    RST = 1'b1;
    miss_valid = 1'b0; miss_set_index = '0; miss_addr = '0;
    miss_dirty = 1'b0; miss_victim_addr = '0;
    mem_rd_req_ready = 1'b0; mem_rd_resp_valid = 1'b0; mem_rd_resp_data = '0;
    mem_wr_req_ready = 1'b0;
    preload_en = 1'b1; preload_idx = 10'h105; preload_data = line_5a;
    ref_ram[32'h105] = line_5a;

    // Reset state
    @(negedge clk);
    check_b("rst_rd_valid", mem_rd_req_valid, 1'b0);
    check_b("rst_wr_valid", mem_wr_req_valid, 1'b0);
    check_b("rst_en", memEN_2, 1'b0);
    check_b("rst_fill_done", fill_done, 1'b0);
    check("rst_data_mem_in", Data_mem_in, '0);
    check("rst_set_index_repl", DW'(Set_Index_repl), '0);
    check("rst_rd_addr", DW'(mem_rd_addr), '0);
    check("rst_wr_data", mem_wr_data, '0);
    check_stats("rst");
    tick();
    preload_en = 1'b0;
    tick();
    RST = 1'b0;
    tick();

    // Dirty miss on the preloaded 0x5A.. line, then a clean miss with zero-wait memory
    do_miss(10'h105, 32'h3000, 1'b1, 32'h2000, 0, 0, 0, 1'b0, rand_line());
    do_miss(10'h105, 32'h1000, 1'b0, 32'h0, 0, 0, 0, 1'b0, line_a5);

    // Stray response while idle
    en0 = en_cnt;
    mem_rd_resp_valid = 1'b1; mem_rd_resp_data = rand_line();
    @(negedge clk);
    check_b("stray_idle_no_en", memEN_2, 1'b0);
    tick();
    mem_rd_resp_valid = 1'b0;
    @(negedge clk);
    check_b("stray_idle_ready", miss_ready, 1'b1);
    check("stray_idle_en_count", DW'(en_cnt - en0), DW'(0));
    tick();

    // Backpressure: read request held for 5 cycles, write request for 3
    do_miss(SI_W'($urandom_range(0, 1023)), $urandom, 1'b1, $urandom,
            5, $urandom_range(0, 3), 3, 1'b0, rand_line());
    // Stray response during RD_REQ
    do_miss(SI_W'($urandom_range(0, 1023)), $urandom, 1'b0, $urandom,
            2, 1, 0, 1'b1, rand_line());

    // Reset while in RD_WAIT, then a late response arrives
    rd0 = rd_hs; en0 = en_cnt;
    miss_valid = 1'b1; miss_set_index = SI_W'($urandom); miss_addr = $urandom;
    miss_dirty = 1'b1; miss_victim_addr = $urandom;
    tick();
    miss_valid = 1'b0; mem_rd_req_ready = 1'b1;
    @(negedge clk);
    check_b("abort_rd_valid", mem_rd_req_valid, 1'b1);
    tick();
    mem_rd_req_ready = 1'b0;
    @(negedge clk);
    RST = 1'b1;
    exp_refills = 0; exp_wbs = 0;
    #1;
    check_b("abort_rst_rd_valid", mem_rd_req_valid, 1'b0);
    check_b("abort_rst_en", memEN_2, 1'b0);
    check("abort_rst_rd_addr", DW'(mem_rd_addr), '0);
    check("abort_rst_data", Data_mem_in, '0);
    check_stats("abort_rst");
    tick();
    tick();
    RST = 1'b0;
    mem_rd_resp_valid = 1'b1; mem_rd_resp_data = rand_line();
    @(negedge clk);
    check_b("abort_ready_after_rst", miss_ready, 1'b1);
    tick();
    mem_rd_resp_valid = 1'b0;
    @(negedge clk);
    check_b("abort_no_en", memEN_2, 1'b0);
    tick();
    @(negedge clk);
    check("abort_en_count", DW'(en_cnt - en0), DW'(0));
    check("abort_rd_hs", DW'(rd_hs - rd0), DW'(1));
    check_b("abort_no_wr", mem_wr_req_valid, 1'b0);
    tick();

    // Statistics: three misses, two dirty, with colliding indices and random stalls
    for (int k = 0; k < 3; k++) begin
      do_miss(SI_W'($urandom_range(0, 3)), $urandom, (k != 0), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              1'b0, rand_line());
    end
`ifdef REFILL_STATS_EN
    check("final_refill_cnt", DW'(refill_cnt), DW'(3));
    check("final_wb_cnt", DW'(wb_cnt), DW'(2));
`else
    check("final_refill_cnt", DW'(refill_cnt), DW'(0));
    check("final_wb_cnt", DW'(wb_cnt), DW'(0));
`endif
    check("scoreboard_empty", DW'(exp_q.size()), DW'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
